pc_branch_fetch: RTL

- Fetch-side program-counter stage of the 16-bit datapath.
- Holds the PC and issues instruction-memory reads with a req/ready handshake.
- Resolves the "branch if a0 == 0" condition and exports the sequential PC, the registered branch target and the registered select bit to the downstream 16-bit 2:1 PC-select mux.
- Owns all sequencing: reset vector, stalls, flush on taken branch.

---
 rtl/pc_branch_fetch.sv | 103 ++++++++++
 1 files changed

// File: rtl/pc_branch_fetch.sv
// Fetch-side PC stage: holds the PC, issues req/ready instruction reads, resolves
// "branch if a0 == 0" and feeds the downstream PC-select mux. Optional macro: PCU_TAKEN_CNT_EN.
module pc_branch_fetch #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] PC_STEP      = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_req,
    input  logic [15:0] branch_target,
    input  logic [15:0] a0_value,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] pc,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] seq_pc,
    output logic [15:0] tgt_pc,
    output logic        mux_sel,
    output logic [15:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] pc_reg;
    logic [15:0] instr_reg;
    logic        instr_valid_reg;
    logic [15:0] tgt_pc_reg;
    logic        mux_sel_reg;
    logic        taken;

    assign taken     = branch_req && (a0_value == 16'h0000);
    assign seq_pc    = pc_reg + PC_STEP;
    assign imem_req  = (state_reg == FETCH);
    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign instr     = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign tgt_pc    = tgt_pc_reg;
    assign mux_sel   = mux_sel_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_VECTOR;
            instr_reg       <= 16'h0000;
            instr_valid_reg <= 1'b0;
            tgt_pc_reg      <= 16'h0000;
            mux_sel_reg     <= 1'b0;
        end else begin
            instr_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: state_reg <= stall ? STALL : FETCH;
                FETCH: begin
                    if (imem_ready) begin
                        // A taken branch in the same cycle squashes the returned word.
                        if (!taken) begin
                            instr_reg       <= imem_rdata;
                            instr_valid_reg <= 1'b1;
                        end
                        pc_reg <= seq_pc;
                    end
                    state_reg <= stall ? STALL : FETCH;
                end
                STALL: state_reg <= stall ? STALL : FETCH;
                default: state_reg <= IDLE;
            endcase
            if (branch_req) begin
                tgt_pc_reg  <= branch_target;
                mux_sel_reg <= taken;
            end
            // Placed last so a taken branch overrides the sequential increment.
            if (taken) begin
                pc_reg <= branch_target;
            end
        end
    end

`ifdef PCU_TAKEN_CNT_EN
    logic [15:0] taken_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_reg <= 16'h0000;
        end else if (taken && (taken_cnt_reg != 16'hFFFF)) begin
            taken_cnt_reg <= taken_cnt_reg + 16'd1;
        end
    end

    assign taken_cnt = taken_cnt_reg;
`else
    assign taken_cnt = 16'h0000;
`endif

endmodule
